// File: rtl/led_fade_driver.sv
// rtl/led_fade_driver.sv - per-channel PWM LED fader with bypass; optional square-law duty via LED_FADE_GAMMA_EN
module led_fade_driver #(
  parameter int PRESCALE = 16,
  parameter int STEP     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] leds,
  output logic [7:0] led_out,
  output logic [7:0] fading
);

  // Prescaler width never drops below one bit so PRESCALE=1 still builds.
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [8:0]    STEP9    = 9'(STEP);

  logic [7:0]      r_leds_q;
  logic [PW-1:0]   r_pre_cnt;
  logic [7:0]      r_pwm_cnt;
  logic [7:0][7:0] r_bright;
  logic [7:0]      r_led_out;
  logic [7:0]      r_fading;

  logic            w_tick;
  logic            w_period_end;
  logic [7:0][8:0] w_up;
  logic [7:0][8:0] w_dn;
  logic [7:0][7:0] w_bright_nxt;
  logic [7:0][7:0] w_duty;
  logic [7:0]      w_led_nxt;
  logic [7:0]      w_fading_nxt;

  assign w_tick       = (r_pre_cnt == PRE_LAST);
  assign w_period_end = w_tick && (r_pwm_cnt == 8'hFF);
  assign led_out      = r_led_out;
  assign fading       = r_fading;

  // Register the SoC target pattern; this copy is the only target source.
  always_ff @(posedge clk) begin
    if (reset) r_leds_q <= 8'h00;
    else       r_leds_q <= leds;
  end

  // Prescaler and PWM ramp run continuously, including in bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= 8'h00;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PW'(1);
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  // Next brightness: bypass snaps to the target, otherwise a saturating step once per period.
  // Both sums are 9 bits wide; bit 8 flags overflow (up) or borrow (down).
  always_comb begin
    w_up         = '0;
    w_dn         = '0;
    w_bright_nxt = r_bright;
    for (int i = 0; i < 8; i++) begin
      w_up[i] = {1'b0, r_bright[i]} + STEP9;
      w_dn[i] = {1'b0, r_bright[i]} - STEP9;
      if (!enable) begin
        w_bright_nxt[i] = r_leds_q[i] ? 8'hFF : 8'h00;
      end else if (w_period_end) begin
        if (r_leds_q[i]) w_bright_nxt[i] = w_up[i][8] ? 8'hFF : w_up[i][7:0];
        else             w_bright_nxt[i] = w_dn[i][8] ? 8'h00 : w_dn[i][7:0];
      end
    end
  end

  // Brightness state; a reset mid-fade drops straight to zero.
  always_ff @(posedge clk) begin
    if (reset) r_bright <= '0;
    else       r_bright <= w_bright_nxt;
  end

`ifdef LED_FADE_GAMMA_EN
  logic [7:0][15:0] w_sq;

  // Square-law duty: upper byte of bright squared.
  always_comb begin
    w_sq   = '0;
    w_duty = '0;
    for (int i = 0; i < 8; i++) begin
      w_sq[i]   = 16'(r_bright[i]) * 16'(r_bright[i]);
      w_duty[i] = w_sq[i][15:8];
    end
  end
`else
  // Linear duty: brightness is the compare threshold directly.
  always_comb begin
    w_duty = r_bright;
  end
`endif

  // Pin drive and fading flags; full brightness forces a solid 1 regardless of duty.
  always_comb begin
    w_led_nxt    = 8'h00;
    w_fading_nxt = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (enable) begin
        w_led_nxt[i]    = (r_bright[i] == 8'hFF) | (r_pwm_cnt < w_duty[i]);
        w_fading_nxt[i] = r_leds_q[i] ? (r_bright[i] != 8'hFF) : (r_bright[i] != 8'h00);
      end else begin
        w_led_nxt[i]    = r_leds_q[i];
        w_fading_nxt[i] = 1'b0;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led_out <= 8'h00;
      r_fading  <= 8'h00;
    end else begin
      r_led_out <= w_led_nxt;
      r_fading  <= w_fading_nxt;
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// tb/tb_led_fade_driver.sv - directed-vector bench for led_fade_driver (PRESCALE=1, STEP=4)
module tb_led_fade_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] leds;
  logic [7:0] led_out;
  logic [7:0] fading;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_fade_driver #(.PRESCALE(1), .STEP(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .leds    (leds),
    .led_out (led_out),
    .fading  (fading)
  );

  // High samples of led_out[0] over one 256-cycle period at a given brightness.
  function automatic int exp_duty(input int b);
    if (b >= 255) return 256;
`ifdef LED_FADE_GAMMA_EN
    return (b * b) >> 8;
`else
    return b;
`endif
  endfunction

  task automatic step_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [7:0] l, input logic en);
    reset  = 1'b1;
    leds   = l;
    enable = en;
    step_edge();
    reset  = 1'b0;
  endtask

  task automatic run_period(output int hi0, output int last_hi, output logic [7:0] or_out,
                            output logic [7:0] and_fad, output logic [7:0] or_fad);
    hi0 = 0; last_hi = -1; or_out = 8'h00; and_fad = 8'hFF; or_fad = 8'h00;
    for (int s = 0; s < 256; s++) begin
      step_edge();
      if (led_out[0]) begin hi0++; last_hi = s; end
      or_out  = or_out | led_out;
      and_fad = and_fad & fading;
      or_fad  = or_fad | fading;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; leds = 8'hFF;
    step_edge(); step_edge();
    n_vec++; if (led_out !== 8'h00) begin n_bad++; $display("FAIL reset_led_out: got %h want 00", led_out); end
    n_vec++; if (fading !== 8'h00) begin n_bad++; $display("FAIL reset_fading: got %h want 00", fading); end
    enable = 1'b0;
    step_edge(); step_edge();
    n_vec++; if (led_out !== 8'h00) begin n_bad++; $display("FAIL reset_hold_bypass: got %h want 00", led_out); end
  endtask

  task automatic test_bypass();
    do_reset(8'h00, 1'b0);
    leds = 8'hA5;
    step_edge();
    n_vec++; if (led_out !== 8'h00) begin n_bad++; $display("FAIL bypass_lat1: got %h want 00", led_out); end
    step_edge();
    n_vec++; if (led_out !== 8'hA5) begin n_bad++; $display("FAIL bypass_lat2: got %h want a5", led_out); end
    n_vec++; if (fading !== 8'h00) begin n_bad++; $display("FAIL bypass_fading: got %h want 00", fading); end
    leds = 8'h5A;
    step_edge();
    n_vec++; if (led_out !== 8'hA5) begin n_bad++; $display("FAIL bypass_lat1b: got %h want a5", led_out); end
    step_edge();
    n_vec++; if (led_out !== 8'h5A) begin n_bad++; $display("FAIL bypass_lat2b: got %h want 5a", led_out); end
  endtask

  task automatic test_fade_in();
    int hi, lh, b;
    logic [7:0] oo, af, of;
    do_reset(8'h00, 1'b1);
    leds = 8'h01;
    for (int p = 0; p <= 64; p++) begin
      run_period(hi, lh, oo, af, of);
      b = (4 * p > 255) ? 255 : 4 * p;
      n_vec++; if (hi !== exp_duty(b)) begin n_bad++; $display("FAIL fade_in_duty p=%0d: got %0d want %0d", p, hi, exp_duty(b)); end
      n_vec++; if (oo[7:1] !== 7'h00) begin n_bad++; $display("FAIL fade_in_other p=%0d: got %h want 00", p, oo[7:1]); end
      n_vec++; if (of[7:1] !== 7'h00) begin n_bad++; $display("FAIL fade_in_other_fad p=%0d: got %h want 00", p, of[7:1]); end
      if (p >= 1 && p < 64) begin
        n_vec++; if (af[0] !== 1'b1) begin n_bad++; $display("FAIL fade_in_fading p=%0d: got %b want 1", p, af[0]); end
      end
      if (p == 64) begin
        n_vec++; if (of[0] !== 1'b0) begin n_bad++; $display("FAIL fade_in_settled p=%0d: got %b want 0", p, of[0]); end
      end
    end
  endtask

  task automatic test_duty();
    int hi, lh;
    logic [7:0] oo, af, of;
    do_reset(8'h00, 1'b1);
    leds = 8'h01;
    repeat (16) run_period(hi, lh, oo, af, of);
    leds = 8'h00;
    run_period(hi, lh, oo, af, of);
    n_vec++; if (hi !== exp_duty(64)) begin n_bad++; $display("FAIL duty_64: got %0d want %0d", hi, exp_duty(64)); end
    n_vec++; if (af[0] !== 1'b1) begin n_bad++; $display("FAIL duty_fading: got %b want 1", af[0]); end
    run_period(hi, lh, oo, af, of);
    n_vec++; if (hi !== exp_duty(60)) begin n_bad++; $display("FAIL duty_60: got %0d want %0d", hi, exp_duty(60)); end
  endtask

  task automatic test_reversal();
    int hi, lh, b;
    logic [7:0] oo, af, of;
    do_reset(8'h00, 1'b1);
    leds = 8'h01;
    repeat (25) run_period(hi, lh, oo, af, of);
    leds = 8'h00;
    for (int p = 25; p <= 50; p++) begin
      run_period(hi, lh, oo, af, of);
      b = 100 - 4 * (p - 25);
      n_vec++; if (hi !== exp_duty(b)) begin n_bad++; $display("FAIL reversal_duty p=%0d: got %0d want %0d", p, hi, exp_duty(b)); end
      if (p < 50) begin
        n_vec++; if (af[0] !== 1'b1) begin n_bad++; $display("FAIL reversal_fading p=%0d: got %b want 1", p, af[0]); end
      end else begin
        n_vec++; if (of !== 8'h00) begin n_bad++; $display("FAIL reversal_done_fading: got %h want 00", of); end
        n_vec++; if (oo !== 8'h00) begin n_bad++; $display("FAIL reversal_done_out: got %h want 00", oo); end
      end
    end
  endtask

  task automatic test_fade_out();
    int hi, lh, b;
    logic [7:0] oo, af, of;
    do_reset(8'hFF, 1'b0);
    run_period(hi, lh, oo, af, of);
    n_vec++; if (led_out !== 8'hFF) begin n_bad++; $display("FAIL fade_out_bypass: got %h want ff", led_out); end
    n_vec++; if (of !== 8'h00) begin n_bad++; $display("FAIL fade_out_bypass_fad: got %h want 00", of); end
    enable = 1'b1;
    leds   = 8'h00;
    for (int p = 1; p <= 65; p++) begin
      run_period(hi, lh, oo, af, of);
      b = (p == 1) ? 255 : ((255 - 4 * (p - 1) < 0) ? 0 : 255 - 4 * (p - 1));
      n_vec++; if (hi !== exp_duty(b)) begin n_bad++; $display("FAIL fade_out_duty p=%0d: got %0d want %0d", p, hi, exp_duty(b)); end
      if (p >= 2 && p <= 64) begin
        n_vec++; if (af !== 8'hFF) begin n_bad++; $display("FAIL fade_out_fading p=%0d: got %h want ff", p, af); end
      end
      if (p == 65) begin
        n_vec++; if (oo !== 8'h00) begin n_bad++; $display("FAIL fade_out_off: got %h want 00", oo); end
        n_vec++; if (of !== 8'h00) begin n_bad++; $display("FAIL fade_out_fad_off: got %h want 00", of); end
      end
    end
  endtask

  task automatic test_reset_mid_fade();
    int hi, lh;
    logic [7:0] oo, af, of;
    do_reset(8'h00, 1'b1);
    leds = 8'h01;
    repeat (32) run_period(hi, lh, oo, af, of);
    repeat (10) step_edge();
    n_vec++; if (led_out[0] !== 1'b1) begin n_bad++; $display("FAIL mid_pre_led: got %b want 1", led_out[0]); end
    n_vec++; if (fading[0] !== 1'b1) begin n_bad++; $display("FAIL mid_pre_fading: got %b want 1", fading[0]); end
    reset = 1'b1;
    step_edge();
    reset = 1'b0;
    n_vec++; if (led_out !== 8'h00) begin n_bad++; $display("FAIL mid_reset_led: got %h want 00", led_out); end
    n_vec++; if (fading !== 8'h00) begin n_bad++; $display("FAIL mid_reset_fading: got %h want 00", fading); end
    run_period(hi, lh, oo, af, of);
    n_vec++; if (hi !== 0) begin n_bad++; $display("FAIL mid_restart_p0: got %0d want 0", hi); end
    run_period(hi, lh, oo, af, of);
    n_vec++; if (hi !== exp_duty(4)) begin n_bad++; $display("FAIL mid_restart_p1: got %0d want %0d", hi, exp_duty(4)); end
    n_vec++; if (lh !== exp_duty(4) - 1) begin n_bad++; $display("FAIL mid_restart_phase: got %0d want %0d", lh, exp_duty(4) - 1); end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; leds = 8'h00;
    test_reset();
    test_bypass();
    test_fade_in();
    test_duty();
    test_reversal();
    test_fade_out();
    test_reset_mid_fade();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
